// File: rtl/minisrc_control_unit.sv
// Hardwired control sequencer for the Mini SRC CPU.
// Steps through fetch (T0-T2) and each instruction's execute phase (T3-T7).
// It issues register, bus, memory, select-and-encode and ALU controls that
// drive the datapath. All controls are a combinational decode of the current
// state and the IR opcode.
module minisrc_control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  output logic        PC_in,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        HI_in,
  output logic        LO_in,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        OutPort_in,
  output logic        IncPC,
  output logic        CON_in,
  output logic        PC_out,
  output logic        Zhigh_out,
  output logic        Zlow_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        MDR_out,
  output logic        InPort_out,
  output logic        C_out,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [15:0] RX_in_man,
  output logic [4:0]  alu_instruction_bits,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [4:0] {
    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
    OP_SHR, OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_DIV, OP_MUL,
    OP_NEG, OP_NOT, OP_BR, OP_JR, OP_JAL, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
    OP_NOP, OP_HALT
  } opcode_e;

  // Instructions sharing an execute sequence are grouped so the per-state
  // decode below stays small.
  typedef enum logic [3:0] {
    G_ALU3, G_IMM, G_MULDIV, G_UNARY, G_LDI, G_LD, G_ST, G_BR,
    G_JR, G_JAL, G_IN, G_OUT, G_MFHI, G_MFLO, G_NOP, G_HALT
  } group_e;

  // ALU code used while computing effective addresses and branch targets.
  localparam logic [4:0] ALU_ADD = 5'b00011;

  state_e     state_q, state_d;
  group_e     grp;
  logic [4:0] opcode;

  assign opcode = IR_Data[31:27];

  // Register/constant fields of IR are decoded by the datapath's
  // select-and-encode logic, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR_Data[26:0];

  // Classify the opcode into its execute-sequence group; reserved codes act as nop.
  always_comb begin
    case (opcode_e'(opcode))
      OP_LD:                        grp = G_LD;
      OP_LDI:                       grp = G_LDI;
      OP_ST:                        grp = G_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL:      grp = G_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:     grp = G_IMM;
      OP_DIV, OP_MUL:               grp = G_MULDIV;
      OP_NEG, OP_NOT:               grp = G_UNARY;
      OP_BR:                        grp = G_BR;
      OP_JR:                        grp = G_JR;
      OP_JAL:                       grp = G_JAL;
      OP_IN:                        grp = G_IN;
      OP_OUT:                       grp = G_OUT;
      OP_MFHI:                      grp = G_MFHI;
      OP_MFLO:                      grp = G_MFLO;
      OP_HALT:                      grp = G_HALT;
      default:                      grp = G_NOP;
    endcase
  end

  // State register; clr forces RST immediately so controls drop mid-cycle.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value of state_d, independent of block evaluation order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= S_RST;
    else     state_q <= state_d;
  end

  // Next-state and control decode from current state and instruction group.
  always_comb begin
    // NOTE: every output gets a default before the case so that paths which
    // do not mention a signal drive 0 instead of inferring a latch.
    PC_in = 1'b0;  IR_in = 1'b0;  Y_in = 1'b0;  Z_in = 1'b0;
    HI_in = 1'b0;  LO_in = 1'b0;  MAR_in = 1'b0;  MDR_in = 1'b0;
    OutPort_in = 1'b0;  IncPC = 1'b0;  CON_in = 1'b0;
    PC_out = 1'b0;  Zhigh_out = 1'b0;  Zlow_out = 1'b0;  HI_out = 1'b0;
    LO_out = 1'b0;  MDR_out = 1'b0;  InPort_out = 1'b0;  C_out = 1'b0;
    Read = 1'b0;  Write = 1'b0;
    Gra = 1'b0;  Grb = 1'b0;  Grc = 1'b0;  Rin = 1'b0;  Rout = 1'b0;  BAout = 1'b0;
    RX_in_man = '0;
    alu_instruction_bits = '0;
    Run = 1'b1;
    state_d = state_q;

    if (state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7})
      alu_instruction_bits = opcode;

    case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        PC_out = 1'b1;  MAR_in = 1'b1;  IncPC = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Read = 1'b1;  MDR_in = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        MDR_out = 1'b1;  IR_in = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        state_d = S_T4;
        case (grp)
          G_ALU3, G_IMM:     begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
          G_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
          G_UNARY:           begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; end
          G_LDI, G_LD, G_ST: begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
          G_BR:              begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
          G_JAL:             begin PC_out = 1'b1; RX_in_man[15] = 1'b1; end
          G_JR: begin
            Gra = 1'b1;  Rout = 1'b1;  PC_in = 1'b1;  state_d = S_T0;
          end
          G_IN: begin
            InPort_out = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = S_T0;
          end
          G_OUT: begin
            Gra = 1'b1;  Rout = 1'b1;  OutPort_in = 1'b1;  state_d = S_T0;
          end
          G_MFHI: begin
            HI_out = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = S_T0;
          end
          G_MFLO: begin
            LO_out = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = S_T0;
          end
          G_HALT:  state_d = S_HALT;
          default: state_d = S_T0;
        endcase
      end
      S_T4: begin
        state_d = S_T5;
        case (grp)
          G_ALU3:   begin Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1; end
          G_IMM:    begin C_out = 1'b1; Z_in = 1'b1; end
          G_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; end
          G_UNARY: begin
            Zlow_out = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = S_T0;
          end
          G_LDI, G_LD, G_ST: begin
            C_out = 1'b1;  Z_in = 1'b1;  alu_instruction_bits = ALU_ADD;
          end
          G_BR:     begin PC_out = 1'b1; Y_in = 1'b1; end
          G_JAL: begin
            Gra = 1'b1;  Rout = 1'b1;  PC_in = 1'b1;  state_d = S_T0;
          end
          default:  state_d = S_T0;
        endcase
      end
      S_T5: begin
        state_d = S_T6;
        case (grp)
          G_ALU3, G_IMM, G_LDI: begin
            Zlow_out = 1'b1;  Gra = 1'b1;  Rin = 1'b1;  state_d = S_T0;
          end
          G_MULDIV:   begin Zlow_out = 1'b1; LO_in = 1'b1; end
          G_LD, G_ST: begin Zlow_out = 1'b1; MAR_in = 1'b1; end
          G_BR: begin
            C_out = 1'b1;  Z_in = 1'b1;  alu_instruction_bits = ALU_ADD;
          end
          default:    state_d = S_T0;
        endcase
      end
      S_T6: begin
        state_d = S_T7;
        case (grp)
          G_MULDIV: begin
            Zhigh_out = 1'b1;  HI_in = 1'b1;  state_d = S_T0;
          end
          G_LD: begin Read = 1'b1; MDR_in = 1'b1; end
          G_ST: begin Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; end
          G_BR: begin
            // Not-taken branch still spends T6, just with no transfers.
            Zlow_out = CON_out;  PC_in = CON_out;  state_d = S_T0;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T7: begin
        state_d = S_T0;
        case (grp)
          G_LD:    begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          G_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      S_HALT: begin
        Run = 1'b0;
        state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Self-checking bench for minisrc_control_unit. Per-instruction expected
// control sequences come from a step-list reference model. They are queued
// cycle by cycle and a monitor compares them at each falling edge.
module tb_minisrc_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR_Data;
  logic        CON_out;
  logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in;
  logic IncPC, CON_in, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out;
  logic InPort_out, C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Run;
  logic [15:0] RX_in_man;
  logic [4:0]  alu_instruction_bits;

  minisrc_control_unit dut (
    .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out),
    .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in),
    .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in),
    .IncPC(IncPC), .CON_in(CON_in), .PC_out(PC_out), .Zhigh_out(Zhigh_out),
    .Zlow_out(Zlow_out), .HI_out(HI_out), .LO_out(LO_out), .MDR_out(MDR_out),
    .InPort_out(InPort_out), .C_out(C_out), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .RX_in_man(RX_in_man), .alu_instruction_bits(alu_instruction_bits), .Run(Run)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [26:0] flags;
    logic [15:0] rx;
    logic [4:0]  alu;
    logic        run;
  } ctrl_t;

  // Bit i of ctrl_t.flags corresponds to names[i].
  string names [27] = '{"PC_in", "IR_in", "Y_in", "Z_in", "HI_in", "LO_in",
    "MAR_in", "MDR_in", "OutPort_in", "IncPC", "CON_in", "PC_out",
    "Zhigh_out", "Zlow_out", "HI_out", "LO_out", "MDR_out", "InPort_out",
    "C_out", "Read", "Write", "Gra", "Grb", "Grc", "Rin", "Rout", "BAout"};

  ctrl_t dut_v;
  always_comb begin
    dut_v.flags = {BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, C_out,
                   InPort_out, MDR_out, LO_out, HI_out, Zlow_out, Zhigh_out,
                   PC_out, CON_in, IncPC, OutPort_in, MDR_in, MAR_in, LO_in,
                   HI_in, Z_in, Y_in, IR_in, PC_in};
    dut_v.rx  = RX_in_man;
    dut_v.alu = alu_instruction_bits;
    dut_v.run = Run;
  end

  ctrl_t exp_q[$];
  string tag_q[$];
  ctrl_t plan_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Build a control vector from a space-separated list of asserted signals.
  function automatic ctrl_t mk(string toks, logic [4:0] alu, logic run);
    ctrl_t c;
    string tok;
    c = '0;
    c.alu = alu;
    c.run = run;
    tok = "";
    for (int i = 0; i <= toks.len(); i++) begin
      if (i == toks.len() || toks[i] == 8'h20) begin
        if (tok == "R15") c.rx[15] = 1'b1;
        else for (int j = 0; j < 27; j++) if (names[j] == tok) c.flags[j] = 1'b1;
        tok = "";
      end else begin
        tok = {tok, toks.substr(i, i)};
      end
    end
    return c;
  endfunction

  task automatic check(input string name, input ctrl_t act, input ctrl_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got flags=%h rx=%h alu=%b run=%b, expected flags=%h rx=%h alu=%b run=%b",
               name, act.flags, act.rx, act.alu, act.run,
               exp.flags, exp.rx, exp.alu, exp.run);
    end
  endtask

  // Monitor: one expected vector per clock, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctrl_t e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, dut_v, e);
    end
  end

  // Reference model: the step list an instruction goes through, fetch included.
  task automatic build_plan(input logic [4:0] op, input bit con);
    plan_q.delete();
    plan_q.push_back(mk("PC_out MAR_in IncPC", op, 1'b1));
    plan_q.push_back(mk("Read MDR_in", op, 1'b1));
    plan_q.push_back(mk("MDR_out IR_in", op, 1'b1));
    if (op inside {[5'd3:5'd11]}) begin
      plan_q.push_back(mk("Grb Rout Y_in", op, 1'b1));
      plan_q.push_back(mk("Grc Rout Z_in", op, 1'b1));
      plan_q.push_back(mk("Zlow_out Gra Rin", op, 1'b1));
    end else if (op inside {[5'd12:5'd14]}) begin
      plan_q.push_back(mk("Grb Rout Y_in", op, 1'b1));
      plan_q.push_back(mk("C_out Z_in", op, 1'b1));
      plan_q.push_back(mk("Zlow_out Gra Rin", op, 1'b1));
    end else if (op == 5'd15 || op == 5'd16) begin
      plan_q.push_back(mk("Gra Rout Y_in", op, 1'b1));
      plan_q.push_back(mk("Grb Rout Z_in", op, 1'b1));
      plan_q.push_back(mk("Zlow_out LO_in", op, 1'b1));
      plan_q.push_back(mk("Zhigh_out HI_in", op, 1'b1));
    end else if (op == 5'd17 || op == 5'd18) begin
      plan_q.push_back(mk("Grb Rout Z_in", op, 1'b1));
      plan_q.push_back(mk("Zlow_out Gra Rin", op, 1'b1));
    end else if (op <= 5'd2) begin
      plan_q.push_back(mk("Grb BAout Y_in", op, 1'b1));
      plan_q.push_back(mk("C_out Z_in", 5'b00011, 1'b1));
      if (op == 5'd1) begin
        plan_q.push_back(mk("Zlow_out Gra Rin", op, 1'b1));
      end else begin
        plan_q.push_back(mk("Zlow_out MAR_in", op, 1'b1));
        if (op == 5'd0) begin
          plan_q.push_back(mk("Read MDR_in", op, 1'b1));
          plan_q.push_back(mk("MDR_out Gra Rin", op, 1'b1));
        end else begin
          plan_q.push_back(mk("Gra Rout MDR_in", op, 1'b1));
          plan_q.push_back(mk("Write", op, 1'b1));
        end
      end
    end else if (op == 5'd19) begin
      plan_q.push_back(mk("Gra Rout CON_in", op, 1'b1));
      plan_q.push_back(mk("PC_out Y_in", op, 1'b1));
      plan_q.push_back(mk("C_out Z_in", 5'b00011, 1'b1));
      plan_q.push_back(mk(con ? "Zlow_out PC_in" : "", op, 1'b1));
    end else if (op == 5'd20) plan_q.push_back(mk("Gra Rout PC_in", op, 1'b1));
    else if (op == 5'd21) begin
      plan_q.push_back(mk("PC_out R15", op, 1'b1));
      plan_q.push_back(mk("Gra Rout PC_in", op, 1'b1));
    end
    else if (op == 5'd22) plan_q.push_back(mk("InPort_out Gra Rin", op, 1'b1));
    else if (op == 5'd23) plan_q.push_back(mk("Gra Rout OutPort_in", op, 1'b1));
    else if (op == 5'd24) plan_q.push_back(mk("HI_out Gra Rin", op, 1'b1));
    else if (op == 5'd25) plan_q.push_back(mk("LO_out Gra Rin", op, 1'b1));
    else plan_q.push_back(mk("", op, 1'b1));  // nop, halt, reserved: one empty T3
  endtask

  // Queue one expected vector for the cycle now starting, then advance a clock.
  task automatic expect_cycle(input ctrl_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that enters T0.
  task automatic run_instr(input logic [31:0] ir, input bit con, input string nm);
    IR_Data = ir;
    CON_out = con;
    build_plan(ir[31:27], con);
    for (int i = 0; i < plan_q.size(); i++)
      expect_cycle(plan_q[i], $sformatf("%s T%0d", nm, i));
  endtask

  task automatic do_reset(input int hold);
    clr = 1'b1;
    for (int i = 0; i < hold; i++) expect_cycle(mk("", 5'd0, 1'b1), "reset held");
    clr = 1'b0;
    expect_cycle(mk("", 5'd0, 1'b1), "reset released");
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    clr = 1'b1;
    IR_Data = '0;
    CON_out = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(32'h18918000, 1'b0, "add");
    run_instr({5'b00010, 4'd4, 4'd3, 19'h90}, 1'b0, "st");
    run_instr({5'b10011, 4'd5, 4'd1, 19'h10}, 1'b0, "brnz nt");
    run_instr({5'b10011, 4'd5, 4'd1, 19'h10}, 1'b1, "brnz tk");
    run_instr({5'b10000, 4'd3, 4'd4, 19'h0}, 1'b0, "mul");
    run_instr({5'b10101, 4'd6, 23'h0}, 1'b0, "jal");

    // ld interrupted by clr in T6, while Read is high.
    IR_Data = {5'b00000, 4'd2, 4'd0, 19'h55};
    build_plan(5'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(plan_q[i]);
      tag_q.push_back($sformatf("ld-reset T%0d", i));
      if (i < 6) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    #1;
    clr = 1'b1;
    #1;
    check("ld clr in T6 drops controls", dut_v, mk("", 5'd0, 1'b1));
    @(posedge clk);
    #1;
    do_reset(1);

    for (int k = 0; k < 150; k++) begin
      op = 5'(($urandom() % 31));
      if (op >= 5'd27) op = op + 5'd1;  // skip halt
      r = $urandom();
      run_instr({op, r[26:0]}, 1'($urandom_range(0, 1)), $sformatf("rnd%0d op%0d", k, op));
    end

    run_instr({5'b11011, 27'h0}, 1'b0, "halt");
    for (int i = 0; i < 20; i++) expect_cycle(mk("", 5'd0, 1'b0), $sformatf("HALT %0d", i));
    do_reset(1);
    run_instr({5'b11010, 27'h0}, 1'b0, "nop after halt");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/minisrc_control_unit.md
# minisrc_control_unit

Hardwired control sequencer for the Mini SRC CPU. It issues, cycle by cycle, the register-in/out, memory, select-and-encode and ALU control signals that drive the `datapath` block. It steps through instruction fetch and each instruction's execute phase using the contents of IR and the CON FF result. It sits beside `datapath` in the CPU top level and replaces manual control-signal sequencing.

## Interface

- No parameters.

Ports (all control outputs are active-high):

- `clk`  in  1  system clock; all state changes on the rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `IR_Data`  in  32  current instruction. Opcode is [31:27]; C2 field is [22:19].
- `CON_out`  in  1  branch condition result from the CON FF logic.
- `PC_in`, `IR_in`, `Y_in`, `Z_in`, `HI_in`, `LO_in`, `MAR_in`, `MDR_in`, `OutPort_in`, `IncPC`, `CON_in`  out  1 each  register load enables.
- `PC_out`, `Zhigh_out`, `Zlow_out`, `HI_out`, `LO_out`, `MDR_out`, `InPort_out`, `C_out`  out  1 each  bus drive enables.
- `Read`, `Write`  out  1 each  memory strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, `BAout`  out  1 each  select-and-encode controls.
- `RX_in_man`  out  16  direct register load enables. Only bit 15 is ever used (for `jal`).
- `alu_instruction_bits`  out  5  ALU operation code.
- `Run`  out  1  high while executing; low once halted.

## Operation

States: RST, T0–T7, HALT.

- RST is entered while `clr` is high.
- In T0–T7, all outputs are a combinational decode of the current state and IR opcode.
- Every output not listed for a step is 0.
- The last step of each instruction returns to T0.
- Fetch steps:
  - T0: `PC_out`, `MAR_in`, `IncPC`.
  - T1: `Read`, `MDR_in`.
  - T2: `MDR_out`, `IR_in`.
- ALU code rule:
  - During address and branch-target computation, `alu_instruction_bits` = 00011 (add).
  - Otherwise it equals IR[31:27].
- Execute steps, by opcode group:
  - Three-register ops (add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011):
    - T3: `Grb` `Rout` `Y_in`.
    - T4: `Grc` `Rout` `Z_in`.
    - T5: `Zlow_out` `Gra` `Rin`.
  - Immediate ops (addi 01100, andi 01101, ori 01110): as above, but T4 uses `C_out` instead of `Grc` `Rout`.
  - div 01111, mul 10000:
    - T3: `Gra` `Rout` `Y_in`.
    - T4: `Grb` `Rout` `Z_in`.
    - T5: `Zlow_out` `LO_in`.
    - T6: `Zhigh_out` `HI_in`.
  - neg 10001, not 10010:
    - T3: `Grb` `Rout` `Z_in`.
    - T4: `Zlow_out` `Gra` `Rin`.
  - ldi 00001:
    - T3: `Grb` `BAout` `Y_in`.
    - T4: `C_out` `Z_in`.
    - T5: `Zlow_out` `Gra` `Rin`.
  - ld 00000: T3–T4 as ldi, then:
    - T5: `Zlow_out` `MAR_in`.
    - T6: `Read` `MDR_in`.
    - T7: `MDR_out` `Gra` `Rin`.
  - st 00010: T3–T5 as ld, then:
    - T6: `Gra` `Rout` `MDR_in` (with `Read`=0, MDR loads from the bus).
    - T7: `Write`.
  - br 10011:
    - T3: `Gra` `Rout` `CON_in`.
    - T4: `PC_out` `Y_in`.
    - T5: `C_out` `Z_in`.
    - T6: `Zlow_out` `PC_in` only when `CON_out`=1; otherwise all controls are 0 and T6 is still consumed.
  - jr 10100:
    - T3: `Gra` `Rout` `PC_in`.
  - jal 10101:
    - T3: `PC_out` `RX_in_man[15]`.
    - T4: `Gra` `Rout` `PC_in`.
  - in 10110: T3: `InPort_out` `Gra` `Rin`.
  - out 10111: T3: `Gra` `Rout` `OutPort_in`.
  - mfhi 11000: T3: `HI_out` `Gra` `Rin`.
  - mflo 11001: T3: `LO_out` `Gra` `Rin`.
  - nop 11010: T3, no controls.
  - Opcodes 11100–11111: treated as nop.
  - halt 11011: T3 → HALT.
- HALT: all controls 0, `Run`=0. HALT is left only via `clr`.

## Timing

- Reset: while `clr` is high, state = RST. All 1-bit controls are 0, `RX_in_man` = 0, `alu_instruction_bits` = 0, `Run` = 1.
- The first rising edge with `clr` low moves RST → T0. T0 is therefore active in the cycle after reset is released.
- Reset asserted mid-instruction, including mid-`Write` in T7: state goes to RST immediately (asynchronously) and all controls drop in the same cycle.
- Each state lasts exactly one clock. There are no wait states.
- Instruction latency, fetch included, in clocks:
  - 4: jr, in, out, mfhi, mflo, nop.
  - 5: jal, neg, not.
  - 6: three-register ops, immediate ops, ldi.
  - 7: mul, div, br (taken or not).
  - 8: ld, st.
- `IR_Data` is sampled only in T3 onward. It is stable because IR loads at the end of T2.
- `CON_out` is sampled in T6 of br. CON FF loaded at the end of T3 is valid there.

## Test plan

- Reset then idle: hold `clr` for 2 cycles → all outputs 0 and `Run`=1. Release → T0 asserts `PC_out`/`MAR_in`/`IncPC`. T1 asserts `Read`/`MDR_in`.
- add R1,R2,R3 (IR = 0x18918000): T3 `Grb` `Rout` `Y_in`; T4 `Grc` `Rout` `Z_in`, `alu_instruction_bits` = 00011; T5 `Zlow_out` `Gra` `Rin`; next cycle T0.
- st 0x90(R3),R4: T4 ALU code 00011; T6 `Rout` `MDR_in` with `Read`=0; T7 `Write`=1 for exactly one cycle.
- brnz with `CON_out`=0 in T6 → no `PC_in` in T6, T0 follows. Repeat with `CON_out`=1 → `Zlow_out` `PC_in` in T6.
- mul → T5 `Zlow_out` `LO_in`; T6 `Zhigh_out` `HI_in`.
- jal → T3 `RX_in_man` = 0x8000 with `PC_out`.
- halt → HALT with `Run`=0, stable for 20 cycles. Then `clr` pulse → RST, then T0 with `Run`=1.
- Reset mid-ld: `clr` asserted in T6 → `Read` drops the same cycle; fetch restarts at T0 after release.
